muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the execute stage and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- MFHI and MFLO read the `hi`/`lo` outputs directly.
- Multi-cycle: start/busy/done handshake. The controller stalls the pipeline while `busy` is high.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    trial  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    // trial < 2*divisor, so bit WIDTH of the difference is a reliable borrow
    diff   = trial - {1'b0, opnd};
    nxt_hi = '0;
    nxt_lo = '0;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Handshake: start is sampled only in IDLE; busy is high in RUN and FIX; done pulses one cycle in DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           dbg_state
);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_hi;
  logic             neg_lo;
  logic             dz;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;

  logic             op_mul, op_div, op_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  always_comb begin
    op_mul = (op == OP_MULT) || (op == OP_MULTU);
    op_div = (op == OP_DIV)  || (op == OP_DIVU);
    op_sgn = (op == OP_MULT) || (op == OP_DIV);
    a_neg  = op_sgn && a[WIDTH-1];
    b_neg  = op_sgn && b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude
    mag_a  = a_neg ? -a : a;
    mag_b  = b_neg ? -b : b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((op == OP_MTHI) || (op == OP_MTLO)) state_n = DONE;
          else if (op_div && (b == '0))            state_n = FIX;
          else if (op_mul || op_div)               state_n = RUN;
        end
      end
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_hi (r_hi),
    .acc_lo (r_lo),
    .opnd   (r_opnd),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_comb begin
    prod   = {r_hi[WIDTH-1:0], r_lo};
    prod_s = neg_lo ? -prod : prod;
    if (is_div) begin
      fix_hi = neg_hi ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
      fix_lo = neg_lo ? -r_lo : r_lo;
    end else begin
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
      fix_lo = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      dz     <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (op_mul || op_div)) begin
            cnt    <= '0;
            is_div <= op_div;
            r_hi   <= '0;
            if (op_div && (b == '0)) begin
              // Divide by zero bypasses RUN; FIX then writes hi=a, lo=all-ones unchanged
              r_hi   <= {1'b0, a};
              r_lo   <= '1;
              neg_hi <= 1'b0;
              neg_lo <= 1'b0;
              dz     <= 1'b1;
            end else begin
              r_lo   <= op_div ? mag_a : mag_b;
              r_opnd <= op_div ? mag_b : mag_a;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= op_div ? a_neg : (a_neg ^ b_neg);
              dz     <= 1'b0;
            end
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        RUN: begin
          r_hi <= step_hi;
          r_lo <= step_lo;
          cnt  <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        DONE:    dz <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy        = (state == RUN) || (state == FIX);
  assign done        = (state == DONE);
  assign div_by_zero = done && dz;
  assign dbg_state   = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written handshake/reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  state_t       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[13];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op for one edge, then follow it to its done pulse.
  // en: edges after the accept edge until done is seen (also the busy-cycle count).
  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input int en, input bit disturb);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0; nb = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      if (disturb && n == 3) begin
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
      end
      if (disturb && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(en));
    chk({nm, " busy_cycles"}, 64'(nb), 64'(en));
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " dz"}, 64'(div_by_zero), 64'(edz));
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, 64'(done), 64'd0);
    chk({nm, " dz_after"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    int en;
    int dcount;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OP_DIV,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[12] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};

    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dz", 64'(div_by_zero), 64'd0);
    chk("reset state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].dz ? 1 : W + 1;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, en, 1'b0);
    end

    // MTHI then MTLO back to back; each completes with no busy and done in the next cycle
    run_op("mthi", OP_MTHI, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_000E, 1'b0, 0, 1'b0);
    run_op("mtlo", OP_MTLO, 32'h0000_5678, 32'h0, 32'h0000_1234, 32'h0000_5678, 1'b0, 0, 1'b0);

    // A start presented during DONE is dropped
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA_0001;
    @(posedge clk); #1;
    chk("mthi2 done", 64'(done), 64'd1);
    op = OP_MTLO; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done hi", 64'(hi), 64'hAAAA_0001);
    chk("start_in_done lo", 64'(lo), 64'h0000_5678);
    chk("start_in_done state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    chk("start_in_done no_done", 64'(done), 64'd0);

    // Reserved op: no done, no state change
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reserved state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    chk("reserved done", 64'(done), 64'd0);
    chk("reserved hi", 64'(hi), 64'hAAAA_0001);

    // Second MULT while busy must not disturb the first
    run_op("busy_ignore", OP_MULT, 32'h0000_1000, 32'h0000_0003, 32'h0, 32'h0000_3000, 1'b0, W + 1, 1'b1);

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("midreset no_done", 64'(dcount), 64'd0);
    chk("midreset lo_held", 64'(lo), 64'd0);
    run_op("after_reset", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, W + 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
